// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector: registered match pulse, early partial-match flag,
// and a saturating match counter. Input bits are consumed only while din_valid is high.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b1101),
  parameter bit                 OVERLAP = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             partial,
  output logic [CNT_W-1:0] match_cnt
);

  if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("seq_detector_param: PAT_LEN must be 2..16 and CNT_W >= 1");
  end

  localparam int            FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0] PART = FW'(PAT_LEN - 1);
  localparam logic [PAT_LEN-2:0] PREFIX = PATTERN[PAT_LEN-1:1];

  logic [PAT_LEN-1:0] history, hist_nx;
  logic [FW-1:0]      fill, fill_nx;
  logic               hit, part_nx;

  always_comb begin
    hist_nx = {history[PAT_LEN-2:0], din};
    fill_nx = (fill == FULL) ? fill : fill + 1'b1;
    hit     = din_valid && (fill_nx == FULL) && (hist_nx == PATTERN);
    // A non-overlapping match flushes the history, so no prefix survives it.
    part_nx = (hit && !OVERLAP) ? 1'b0
            : ((fill_nx >= PART) && (hist_nx[PAT_LEN-2:0] == PREFIX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history   <= '0;
      fill      <= '0;
      dout      <= 1'b0;
      partial   <= 1'b0;
      match_cnt <= '0;
    end else begin
      dout <= hit;
      if (din_valid) begin
        history <= hist_nx;
        fill    <= (hit && !OVERLAP) ? '0 : fill_nx;
        partial <= part_nx;
      end
      // Clear wins over a same-cycle match; the counter never wraps.
      if (cnt_clr)
        match_cnt <= '0;
      else if (hit && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four configurations share one stimulus stream; expectations
// are queued as stimulus is driven and popped once the clock edge has produced outputs.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0, din_valid = 1'b0, cnt_clr = 1'b0;

  logic       dout0, part0, dout1, part1, dout2, part2, dout3, part3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detector_param u0 (.clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .cnt_clr(cnt_clr), .dout(dout0), .partial(part0), .match_cnt(cnt0));

  seq_detector_param #(.OVERLAP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .din(din),
    .din_valid(din_valid), .cnt_clr(cnt_clr), .dout(dout1), .partial(part1), .match_cnt(cnt1));

  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
    .dout(dout2), .partial(part2), .match_cnt(cnt2));

  seq_detector_param #(.PAT_LEN(16), .PATTERN(16'hA5C3)) u3 (.clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr), .dout(dout3), .partial(part3),
    .match_cnt(cnt3));

  typedef struct {
    int         sel;
    logic       d;
    logic       p;
    logic [7:0] c;
    string      nm;
  } exp_t;

  typedef struct {
    logic       d, v;
    logic       d0, p0;
    logic [7:0] c0;
    logic       d1, p1;
    logic [7:0] c1;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[9];
  int   npass = 0, ntot = 0;

  function automatic logic [9:0] outs(input int sel);
    case (sel)
      0:       return {dout0, part0, cnt0};
      1:       return {dout1, part1, cnt1};
      2:       return {dout2, part2, 6'd0, cnt2};
      default: return {dout3, part3, cnt3};
    endcase
  endfunction

  task automatic push(input int sel, input logic d, input logic p, input logic [7:0] c,
                      input string nm);
    exp_t e;
    e.sel = sel; e.d = d; e.p = p; e.c = c; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [9:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = outs(e.sel);
      ntot++;
      if (got == {e.d, e.p, e.c}) npass++;
      else $display("FAIL %s u%0d: got dout=%0b partial=%0b cnt=%0d, want dout=%0b partial=%0b cnt=%0d",
                    e.nm, e.sel, got[9], got[8], got[7:0], e.d, e.p, e.c);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input logic d, input logic v, input logic clr);
    din = d; din_valid = v; cnt_clr = clr;
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 1'b0, 1'b0, 8'd0, "reset_state");
    drain();
  endtask

  logic [3:0]  seq4;
  logic [15:0] pat16, m_hist, nh;
  int          m_fill, nf, m_cnt, m_pulses, pulses;
  logic        b, hit, mp;

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 1, 0, 0, 1, 0};
    tbl[3] = '{1, 1, 1, 0, 1, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 0, 1, 0, 0, 1};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 1, 1};
    tbl[6] = '{1, 1, 0, 0, 1, 1, 0, 2};
    tbl[7] = '{1, 0, 0, 0, 1, 0, 0, 2};
    tbl[8] = '{0, 0, 0, 0, 1, 0, 0, 2};
    seq4  = 4'b1101;
    pat16 = 16'hA5C3;

    // Stream 1101101: non-overlapping vs overlapping, then idle cycles.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(0, tbl[i].d0, tbl[i].p0, tbl[i].c0, $sformatf("tbl%0d_novl", i));
      push(1, tbl[i].d1, tbl[i].p1, tbl[i].c1, $sformatf("tbl%0d_ovl", i));
      step(tbl[i].d, tbl[i].v, 1'b0);
    end

    // 1101 with three invalid cycles (random din) after each bit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, i == 3, i == 2, (i == 3) ? 8'd1 : 8'd0, $sformatf("gap_bit%0d", i));
      step(seq4[3-i], 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        push(0, 1'b0, i == 2, (i == 3) ? 8'd1 : 8'd0, $sformatf("gap_idle%0d_%0d", i, k));
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end

    // PAT_LEN=2 "11" overlapping, 2-bit counter saturation, clear vs match priority.
    do_reset();
    push(2, 1'b0, 1'b1, 8'd0, "sat_c0");
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) begin
      push(2, 1'b1, 1'b1, (i < 3) ? 8'(i) : 8'd3, $sformatf("sat_c%0d", i));
      step(1'b1, 1'b1, 1'b0);
    end
    push(2, 1'b1, 1'b1, 8'd0, "clr_beats_match");
    step(1'b1, 1'b1, 1'b1);
    push(2, 1'b1, 1'b1, 8'd1, "count_after_clr");
    step(1'b1, 1'b1, 1'b0);
    push(2, 1'b0, 1'b0, 8'd1, "sat_zero_bit");
    step(1'b0, 1'b1, 1'b0);

    // Async reset mid-pattern: partial drops before the next edge, progress is lost.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, i == 2, 8'd0, $sformatf("pre_rst_bit%0d", i));
      step(seq4[3-i], 1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 push(0, 1'b0, 1'b0, 8'd0, "async_rst_partial");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 1'b0, 1'b0, 8'd0, "post_rst_no_match");
    step(1'b1, 1'b1, 1'b0);

    // Async reset while dout and the counter are set.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, i == 3, i == 2, (i == 3) ? 8'd1 : 8'd0, $sformatf("pre_rst2_bit%0d", i));
      step(seq4[3-i], 1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 push(0, 1'b0, 1'b0, 8'd0, "async_rst_dout");
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // 16-bit pattern after 20 random bits, against a spec-level model.
    do_reset();
    m_hist = '0; m_fill = 0; m_cnt = 0; m_pulses = 0; pulses = 0;
    for (int i = 0; i < 36; i++) begin
      b  = (i < 20) ? 1'($urandom_range(0, 1)) : pat16[35-i];
      nh = {m_hist[14:0], b};
      nf = (m_fill < 16) ? m_fill + 1 : 16;
      hit = (nf == 16) && (nh == pat16);
      mp  = hit ? 1'b0 : ((nf >= 15) && (nh[14:0] == pat16[15:1]));
      m_hist = nh;
      m_fill = hit ? 0 : nf;
      m_cnt += int'(hit);
      m_pulses += int'(hit);
      push(3, hit, mp, 8'(m_cnt), $sformatf("p16_bit%0d", i));
      step(b, 1'b1, 1'b0);
      pulses += int'(dout3);
    end
    ntot++;
    if (pulses == m_pulses && hit) npass++;
    else $display("FAIL p16_final_pulse: got %0d pulses, want %0d ending on the last bit",
                  pulses, m_pulses);
    push(3, 1'b0, 1'b0, 8'(m_cnt), "p16_no_stretch");
    step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
